// File: rtl/lcd_reader_pkg.sv
// Shared definitions for the HD44780 LCD reader and writer: FSM state
// encodings, command codes, RS constants and counter sizing helpers.
// Optional feature macro: LCD_BUSY_POLL_EN (adds the POLL_WAIT state).
package lcd_reader_pkg;

  // Reader FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_EN_HI     = 3'd2,
    ST_HOLD      = 3'd3
`ifdef LCD_BUSY_POLL_EN
    ,
    ST_POLL_WAIT = 3'd4
`endif
  } lcd_state_e;

  // HD44780 command codes used by the writer
  localparam logic [7:0] LCD_CMD_CLEAR       = 8'h01;
  localparam logic [7:0] LCD_CMD_DISP_CURSOR = 8'h0E;
  localparam logic [7:0] LCD_CMD_SHIFT_L     = 8'h10;
  localparam logic [7:0] LCD_CMD_SHIFT_R     = 8'h14;

  // RS pin meaning
  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  // Largest of the four cycle parameters
  function automatic int max_cyc(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Down-counter width able to hold the largest reload value without wrapping
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/lcd_reader_cycle_timer.sv
// Loadable down-counter with a zero flag. Loading N-1 makes the zero flag
// appear on the N-th cycle after the load, so a state lasts N cycles.
// The counter holds at zero instead of wrapping.
module lcd_reader_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign zero_o = (count_q == {W{1'b0}});

  // Next count: reload has priority, otherwise count down and stop at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!zero_o) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read engine: runs one RW=1 cycle (busy/address or data RAM read)
// per rising edge of iStart and returns the captured byte with oDone.
// Optional feature macro: LCD_BUSY_POLL_EN -- busy/address reads repeat,
// separated by POLL_GAP cycles, until the captured busy flag is clear.
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int CLK_Divide = 16,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int POLL_GAP   = 8
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  output logic       oDone,
  output logic [7:0] oDATA,
  output logic       oBF,
  output logic [6:0] oADDR,
  output logic       oBUS_ACT,
  input  logic [7:0] LCD_DQ,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int CNT_W = cnt_width(max_cyc(CLK_Divide, SETUP_CYC, HOLD_CYC, POLL_GAP));

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(CLK_Divide - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
`ifdef LCD_BUSY_POLL_EN
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(POLL_GAP - 1);
`endif

  lcd_state_e state_q;
  lcd_state_e state_d;

  logic       start_s1_q;
  logic       start_s2_q;
  logic       start_s;

  logic       rs_q;
  logic       rs_d;
  logic       en_q;
  logic       rw_q;
  logic       rs_pin_q;
  logic       bus_act_q;
  logic       done_q;
  logic [7:0] data_q;
  logic       bf_q;
  logic [6:0] addr_q;

  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             zero_s;
  logic             capture_s;
  logic             done_set_s;
  logic             done_clr_s;
  logic             latch_rs_s;
  logic             pins_act_s;

  // A start is the first cycle iStart is seen high after being low
  assign start_s = start_s1_q & ~start_s2_q;

  lcd_reader_cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (zero_s)
  );

  // Register iStart twice for edge detection
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
    end else begin
      start_s1_q <= iStart;
      start_s2_q <= start_s1_q;
    end
  end

  // Next-state logic, timer reloads and capture/handshake strobes
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    load_val_s = {CNT_W{1'b0}};
    capture_s  = 1'b0;
    done_set_s = 1'b0;
    done_clr_s = 1'b0;
    latch_rs_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = SETUP_LD;
          done_clr_s = 1'b1;
          latch_rs_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (zero_s) begin
          state_d    = ST_EN_HI;
          load_s     = 1'b1;
          load_val_s = EN_LD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_EN_HI: begin
        if (zero_s) begin
          state_d    = ST_HOLD;
          load_s     = 1'b1;
          load_val_s = HOLD_LD;
          capture_s  = 1'b1;
        end else begin
          state_d = ST_EN_HI;
        end
      end
      ST_HOLD: begin
        if (zero_s) begin
`ifdef LCD_BUSY_POLL_EN
          // Busy reads loop until the panel reports ready
          if ((rs_q == LCD_RS_CMD) && bf_q) begin
            state_d    = ST_POLL_WAIT;
            load_s     = 1'b1;
            load_val_s = GAP_LD;
          end else begin
            state_d    = ST_IDLE;
            done_set_s = 1'b1;
          end
`else
          state_d    = ST_IDLE;
          done_set_s = 1'b1;
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end
`ifdef LCD_BUSY_POLL_EN
      ST_POLL_WAIT: begin
        if (zero_s) begin
          state_d    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = SETUP_LD;
        end else begin
          state_d = ST_POLL_WAIT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin-drive view of the next state: RS/RW valid only inside a read cycle
  always_comb begin
    rs_d       = rs_q;
    pins_act_s = 1'b0;
    if (latch_rs_s) begin
      rs_d = iRS;
    end else begin
      rs_d = rs_q;
    end
    if ((state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_HOLD)) begin
      pins_act_s = 1'b1;
    end else begin
      pins_act_s = 1'b0;
    end
  end

  // FSM state and registered LCD pin controls
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      rs_pin_q  <= 1'b0;
      bus_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      en_q      <= (state_d == ST_EN_HI);
      rw_q      <= pins_act_s;
      rs_pin_q  <= pins_act_s & rs_d;
      bus_act_q <= (state_d != ST_IDLE);
    end
  end

  // Captured byte, status fields and done handshake
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_q <= 8'h00;
      bf_q   <= 1'b0;
      addr_q <= 7'h00;
      done_q <= 1'b0;
    end else begin
      if (capture_s) begin
        data_q <= LCD_DQ;
        if (rs_q == LCD_RS_CMD) begin
          bf_q   <= LCD_DQ[7];
          addr_q <= LCD_DQ[6:0];
        end
      end
      if (done_clr_s) begin
        done_q <= 1'b0;
      end else if (done_set_s) begin
        done_q <= 1'b1;
      end
    end
  end

  assign oDone    = done_q;
  assign oDATA    = data_q;
  assign oBF      = bf_q;
  assign oADDR    = addr_q;
  assign oBUS_ACT = bus_act_q;
  assign LCD_RW   = rw_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_pin_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader. Expected read results are pushed to a
// scoreboard queue when a read is launched and popped when oDone rises.
module tb_lcd_reader;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iStart;
  logic       iRS;
  logic       oDone;
  logic [7:0] oDATA;
  logic       oBF;
  logic [6:0] oADDR;
  logic       oBUS_ACT;
  logic [7:0] LCD_DQ;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  typedef struct {
    logic [7:0] data;
    logic       bf;
    logic [6:0] addr;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int   en_hi_total = 0;
  int   en_pulses   = 0;
  int   low_run     = 0;
  int   last_gap    = 0;
  logic en_prev     = 1'b0;

  logic       model_bf   = 1'b0;
  logic [6:0] model_addr = 7'h00;

  lcd_reader dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (iStart),
    .iRS      (iRS),
    .oDone    (oDone),
    .oDATA    (oDATA),
    .oBF      (oBF),
    .oADDR    (oADDR),
    .oBUS_ACT (oBUS_ACT),
    .LCD_DQ   (LCD_DQ),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  // EN activity monitor sampled on the falling edge
  always @(negedge iCLK) begin
    en_prev <= LCD_EN;
    if (LCD_EN) begin
      en_hi_total <= en_hi_total + 1;
    end
    if (LCD_EN && !en_prev) begin
      en_pulses <= en_pulses + 1;
      last_gap  <= low_run;
      low_run   <= 0;
    end else if (!LCD_EN) begin
      low_run <= low_run + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 late data change, 2 retrigger, 3 iStart held high, 4 busy poll
  task automatic run_read(input logic rs, input logic [7:0] dq, input int mode, input string tag);
    int   k;
    int   hi0;
    int   p0;
    int   exp_lat;
    int   exp_pulses;
    bit   done;
    exp_t e;
    exp_t got;
    hi0        = en_hi_total;
    p0         = en_pulses;
    exp_pulses = (mode == 4) ? 4 : 1;
    exp_lat    = (mode == 4) ? (4 * 20 + 3 * 8 + 1) : 21;
    e.data = dq;
    if (rs == 1'b0) begin
      model_bf   = dq[7];
      model_addr = dq[6:0];
    end
    e.bf   = model_bf;
    e.addr = model_addr;
    sb_q.push_back(e);
    iRS    = rs;
    LCD_DQ = (mode == 1) ? 8'h00 : ((mode == 4) ? 8'h80 : dq);
    @(negedge iCLK);
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    k    = 0;
    done = 1'b0;
    if (mode != 3) iStart = 1'b0;
    while (!done && k < 200) begin
      @(posedge iCLK);
      #1;
      k++;
      if (mode == 1) LCD_DQ = (k == 18) ? dq : 8'h00;
      if (mode == 2) iStart = (k >= 3 && k <= 5);
      if (mode == 4) LCD_DQ = ((en_pulses - p0) >= 4) ? dq : 8'h80;
      if (k == 10) begin
        check({tag, "_rs_pin"}, 32'(LCD_RS), 32'(rs));
        check({tag, "_rw_pin"}, 32'(LCD_RW), 32'h1);
        check({tag, "_bus_act"}, 32'(oBUS_ACT), 32'h1);
      end
      if (oDone) done = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(done), 32'h1);
    got = sb_q.pop_front();
    if (done) begin
      check({tag, "_latency"}, 32'(k), 32'(exp_lat));
      check({tag, "_en_cycles"}, 32'(en_hi_total - hi0), 32'(16 * exp_pulses));
      check({tag, "_en_pulses"}, 32'(en_pulses - p0), 32'(exp_pulses));
      check({tag, "_data"}, 32'(oDATA), 32'(got.data));
      check({tag, "_bf"}, 32'(oBF), 32'(got.bf));
      check({tag, "_addr"}, 32'(oADDR), 32'(got.addr));
      check({tag, "_bus_idle"}, 32'(oBUS_ACT), 32'h0);
      if (mode == 4) check({tag, "_gap"}, 32'(last_gap), 32'd12);
    end
    if (mode == 3) begin
      repeat (30) @(posedge iCLK);
      #1;
      check({tag, "_no_retrig"}, 32'(en_pulses - p0), 32'h1);
      check({tag, "_done_held"}, 32'(oDone), 32'h1);
      iStart = 1'b0;
    end
    repeat (3) @(posedge iCLK);
    #1;
  endtask

  initial begin
    int p0;
    iRST   = 1'b1;
    iStart = 1'b0;
    iRS    = 1'b0;
    LCD_DQ = 8'h00;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_done", 32'(oDone), 32'h0);
    check("rst_data", 32'(oDATA), 32'h0);
    check("rst_bf", 32'(oBF), 32'h0);
    check("rst_addr", 32'(oADDR), 32'h0);
    check("rst_bus", 32'(oBUS_ACT), 32'h0);
    check("rst_rw", 32'(LCD_RW), 32'h0);
    check("rst_en", 32'(LCD_EN), 32'h0);
    check("rst_rs", 32'(LCD_RS), 32'h0);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;

`ifndef LCD_BUSY_POLL_EN
    run_read(1'b0, 8'hA5, 0, "busy_read");
`endif
    run_read(1'b1, 8'h41, 0, "data_read");

    // Reset in the middle of EN high
    p0     = en_pulses;
    iRS    = 1'b0;
    LCD_DQ = 8'h33;
    @(negedge iCLK);
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    repeat (8) @(posedge iCLK);
    @(negedge iCLK);
    check("mid_en_high", 32'(LCD_EN), 32'h1);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    check("mid_rst_en", 32'(LCD_EN), 32'h0);
    check("mid_rst_rw", 32'(LCD_RW), 32'h0);
    check("mid_rst_bus", 32'(oBUS_ACT), 32'h0);
    check("mid_rst_done", 32'(oDone), 32'h0);
    check("mid_rst_data", 32'(oDATA), 32'h0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST       = 1'b0;
    model_bf   = 1'b0;
    model_addr = 7'h00;
    repeat (30) @(posedge iCLK);
    #1;
    check("post_rst_pulses", 32'(en_pulses - p0), 32'h1);
    check("post_rst_bus", 32'(oBUS_ACT), 32'h0);
    check("post_rst_done", 32'(oDone), 32'h0);

    run_read(1'b0, 8'h7E, 1, "sample_pt");
    check("sample_pt_after", 32'(oDATA), 32'h7E);
    run_read(1'b1, 8'h5A, 2, "retrigger");
    run_read(1'b0, 8'h43, 3, "hold_high");
`ifdef LCD_BUSY_POLL_EN
    run_read(1'b0, 8'h12, 4, "busy_poll");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
